// File: rtl/motor_seq_pkg.sv
// Shared types and constants for the two-channel motor drive sequencer.
package motor_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    DEAD = 2'd3
  } chan_state_t;

  localparam logic DIR_FWD  = 1'b1;
  localparam logic DIR_BACK = 1'b0;

  function automatic logic is_busy(input chan_state_t s);
    return (s == RAMP) || (s == DEAD);
  endfunction

endpackage

// File: rtl/motor_channel_fsm.sv
// One motor channel: command handshake, slew-limited duty ramp, reversal dead-time, PWM drive.
module motor_channel_fsm
  import motor_seq_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_STEP   = 4,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                estop,
  input  logic                cmd_valid,
  input  logic [PWM_BITS-1:0] cmd_speed,
  input  logic                cmd_dir,
  output logic                cmd_ready,
  output logic                on,
  output logic                dir,
  output logic                busy
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_CYCLES);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP_W    = PWM_BITS'(RAMP_STEP);
  localparam int unsigned         STEP_U    = RAMP_STEP;

  chan_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, target_q, target_d, duty_step, cnt_nx;
  logic                dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic [DW-1:0]       dead_q, dead_d;
  logic                on_q, on_d, ready_q, ready_d, busy_q, busy_d;
  logic                accept;

  // Saturating move toward tgt; the add/subtract is only taken when it cannot pass tgt.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS-1:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (32'(diff) > STEP_U) ? cur + STEP_W : tgt;
    end else begin
      diff = cur - tgt;
      return (32'(diff) > STEP_U) ? cur - STEP_W : tgt;
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      dir_q      <= DIR_BACK;
      pend_dir_q <= DIR_BACK;
      dead_q     <= '0;
      on_q       <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      dir_q      <= dir_d;
      pend_dir_q <= pend_dir_d;
      dead_q     <= dead_d;
      on_q       <= on_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Handshake: a command is taken on a clock where cmd_valid && cmd_ready are both high.
  // estop on that same clock wins and the command is dropped; cmd_ready is registered,
  // so it falls on the clock after estop rises and stays low until estop is released.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    dir_d      = dir_q;
    pend_dir_d = pend_dir_q;
    dead_d     = dead_q;
    accept     = cmd_valid && ready_q;
    duty_step  = step_toward(duty_q, target_q);
    if (estop) begin
      state_d  = IDLE;
      duty_d   = '0;
      target_d = '0;
      dead_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (accept && (cmd_speed != '0)) begin
          dir_d    = cmd_dir;
          target_d = cmd_speed;
          state_d  = RAMP;
        end
        HOLD: if (accept) begin
          if ((cmd_speed == '0) || (cmd_dir == dir_q)) begin
            target_d = cmd_speed;
            state_d  = RAMP;
          end else begin
            duty_d     = '0;
            dead_d     = DEAD_LOAD;
            pend_dir_d = cmd_dir;
            target_d   = cmd_speed;
            state_d    = DEAD;
          end
        end
        RAMP: begin
          if (duty_q == target_q) begin
            state_d = (target_q == '0) ? IDLE : HOLD;
          end else if (wrap) begin
            duty_d = duty_step;
            if (duty_step == target_q) state_d = (target_q == '0) ? IDLE : HOLD;
          end
        end
        DEAD: begin
          if (dead_q <= DW'(1)) begin
            dead_d  = '0;
            dir_d   = pend_dir_q;
            state_d = RAMP;
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are computed from next-state values so the registered PWM lines up with cnt.
  always_comb begin
    cnt_nx  = cnt + PWM_BITS'(1);
    on_d    = (state_d != DEAD) && ((duty_d > cnt_nx) || (duty_d == DUTY_MAX));
    ready_d = !estop && ((state_d == IDLE) || (state_d == HOLD));
    busy_d  = is_busy(state_d);
  end

  assign cmd_ready = ready_q;
  assign on        = on_q;
  assign dir       = dir_q;
  assign busy      = busy_q;

endmodule

// File: rtl/motor_drive_sequencer.sv
// Two-channel DC motor sequencer feeding the L293D encoder; owns the shared PWM counter.
module motor_drive_sequencer #(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_STEP   = 4,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                estop,
  input  logic                m1_cmd_valid,
  output logic                m1_cmd_ready,
  input  logic [PWM_BITS-1:0] m1_cmd_speed,
  input  logic                m1_cmd_dir,
  input  logic                m2_cmd_valid,
  output logic                m2_cmd_ready,
  input  logic [PWM_BITS-1:0] m2_cmd_speed,
  input  logic                m2_cmd_dir,
  output logic                motor_1_on,
  output logic                motor_1_dir,
  output logic                motor_2_on,
  output logic                motor_2_dir,
  output logic                m1_busy,
  output logic                m2_busy
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q + PWM_BITS'(1);
    wrap  = &cnt_q;
  end

  motor_channel_fsm #(
    .PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrap      (wrap),
    .cnt       (cnt_q),
    .estop     (estop),
    .cmd_valid (m1_cmd_valid),
    .cmd_speed (m1_cmd_speed),
    .cmd_dir   (m1_cmd_dir),
    .cmd_ready (m1_cmd_ready),
    .on        (motor_1_on),
    .dir       (motor_1_dir),
    .busy      (m1_busy)
  );

  motor_channel_fsm #(
    .PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_ch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrap      (wrap),
    .cnt       (cnt_q),
    .estop     (estop),
    .cmd_valid (m2_cmd_valid),
    .cmd_speed (m2_cmd_speed),
    .cmd_dir   (m2_cmd_dir),
    .cmd_ready (m2_cmd_ready),
    .on        (motor_2_on),
    .dir       (motor_2_dir),
    .busy      (m2_busy)
  );

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Bench for motor_drive_sequencer: directed scenarios then random commands, all against a cycle model.
module tb_motor_drive_sequencer;

  localparam int PW = 4, STEP = 4, DEAD = 8, MAXD = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic estop = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid[2];
  logic [3:0] in_speed[2];
  logic       in_dir[2];
  logic m1_cmd_ready, m2_cmd_ready, motor_1_on, motor_1_dir, motor_2_on, motor_2_dir;
  logic m1_busy, m2_busy;

  motor_drive_sequencer #(.PWM_BITS(PW), .RAMP_STEP(STEP), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .estop(estop),
    .m1_cmd_valid(in_valid[0]), .m1_cmd_ready(m1_cmd_ready),
    .m1_cmd_speed(in_speed[0]), .m1_cmd_dir(in_dir[0]),
    .m2_cmd_valid(in_valid[1]), .m2_cmd_ready(m2_cmd_ready),
    .m2_cmd_speed(in_speed[1]), .m2_cmd_dir(in_dir[1]),
    .motor_1_on(motor_1_on), .motor_1_dir(motor_1_dir),
    .motor_2_on(motor_2_on), .motor_2_dir(motor_2_dir),
    .m1_busy(m1_busy), .m2_busy(m2_busy)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // reference model: per-channel phase, duty/target as integers, dead clocks remaining
  typedef enum int {P_IDLE, P_RAMP, P_HOLD, P_DEAD} phase_t;
  phase_t ph[2];
  int     duty[2], tgt[2], dead_left[2];
  bit     mdir[2], pend[2], acc[2];
  int     mcnt;
  bit     last_estop;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      ph[c] = P_IDLE; duty[c] = 0; tgt[c] = 0; dead_left[c] = 0;
      mdir[c] = 1'b0; pend[c] = 1'b0; acc[c] = 1'b0;
    end
    mcnt = 0;
    last_estop = 1'b0;
  endfunction

  function automatic bit exp_ready(int c);
    return ((ph[c] == P_IDLE) || (ph[c] == P_HOLD)) && !last_estop;
  endfunction

  function automatic bit exp_busy(int c);
    return (ph[c] == P_RAMP) || (ph[c] == P_DEAD);
  endfunction

  function automatic bit exp_on(int c);
    return (ph[c] != P_DEAD) && ((duty[c] > mcnt) || (duty[c] == MAXD));
  endfunction

  function automatic void model_tick();
    bit wrap = (mcnt == MAXD);
    for (int c = 0; c < 2; c++) begin
      acc[c] = in_valid[c] && exp_ready(c) && !estop;
      if (estop) begin
        ph[c] = P_IDLE; duty[c] = 0; tgt[c] = 0;
      end else begin
        case (ph[c])
          P_IDLE: if (acc[c] && in_speed[c] != 0) begin
            mdir[c] = in_dir[c]; tgt[c] = int'(in_speed[c]); ph[c] = P_RAMP;
          end
          P_HOLD: if (acc[c]) begin
            if (in_speed[c] == 0 || in_dir[c] == mdir[c]) begin
              tgt[c] = int'(in_speed[c]); ph[c] = P_RAMP;
            end else begin
              duty[c] = 0; dead_left[c] = DEAD; pend[c] = in_dir[c];
              tgt[c] = int'(in_speed[c]); ph[c] = P_DEAD;
            end
          end
          P_RAMP: begin
            if (duty[c] != tgt[c] && wrap)
              duty[c] = (duty[c] < tgt[c]) ? ((duty[c] + STEP < tgt[c]) ? duty[c] + STEP : tgt[c])
                                           : ((duty[c] - STEP > tgt[c]) ? duty[c] - STEP : tgt[c]);
            if (duty[c] == tgt[c]) ph[c] = (tgt[c] == 0) ? P_IDLE : P_HOLD;
          end
          P_DEAD: begin
            dead_left[c]--;
            if (dead_left[c] == 0) begin mdir[c] = pend[c]; ph[c] = P_RAMP; end
          end
          default: ;
        endcase
      end
    end
    last_estop = estop;
    mcnt = (mcnt + 1) % (MAXD + 1);
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_num(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk_bit("m1_on", motor_1_on, exp_on(0));
    chk_bit("m1_dir", motor_1_dir, mdir[0]);
    chk_bit("m1_ready", m1_cmd_ready, exp_ready(0));
    chk_bit("m1_busy", m1_busy, exp_busy(0));
    chk_bit("m2_on", motor_2_on, exp_on(1));
    chk_bit("m2_dir", motor_2_dir, mdir[1]);
    chk_bit("m2_ready", m2_cmd_ready, exp_ready(1));
    chk_bit("m2_busy", m2_busy, exp_busy(1));
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_all();
    for (int c = 0; c < 2; c++) if (acc[c]) in_valid[c] = 1'b0;
  endtask

  task automatic send(input int c, input int spd, input bit d);
    in_valid[c] = 1'b1; in_speed[c] = 4'(spd); in_dir[c] = d;
    for (int i = 0; i < 300 && in_valid[c]; i++) cycle();
    chk_bit("send_accepted", in_valid[c], 1'b0);
    in_valid[c] = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 17 && mcnt != v; i++) cycle();
  endtask

  task automatic wait_settle(input int c);
    for (int i = 0; i < 300 && exp_busy(c); i++) cycle();
    chk_bit("settle_busy", (c == 0) ? m1_busy : m2_busy, 1'b0);
  endtask

  // count on-clocks over one PWM period starting at cnt 0 and compare with the queued value
  task automatic measure(input int c, input string tag);
    int n = 0;
    wait_cnt(0);
    for (int i = 0; i < 16; i++) begin
      n += int'((c == 0) ? motor_1_on : motor_2_on);
      cycle();
    end
    chk_num(tag, n, int'(exp_q.pop_front()));
  endtask

  initial begin
    int n, estop_left, r;
    for (int c = 0; c < 2; c++) begin in_valid[c] = 1'b0; in_speed[c] = '0; in_dir[c] = 1'b0; end
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle();

    // ramp up m1 to 10 forward
    wait_cnt(2);
    send(0, 10, 1'b1);
    chk_bit("up_dir_next_clock", motor_1_dir, 1'b1);
    exp_q.push_back(8'd4); exp_q.push_back(8'd8); exp_q.push_back(8'd10); exp_q.push_back(8'd10);
    for (int i = 0; i < 4; i++) measure(0, "up_period_on");
    chk_bit("up_hold_ready", m1_cmd_ready, 1'b1);

    // m2 full on
    wait_cnt(2);
    send(1, 15, 1'b1);
    exp_q.push_back(8'd4); exp_q.push_back(8'd8); exp_q.push_back(8'd12); exp_q.push_back(8'd16);
    for (int i = 0; i < 4; i++) measure(1, "full_period_on");

    // reversal from HOLD 8 forward to 8 back
    wait_cnt(2);
    send(0, 8, 1'b1);
    wait_settle(0);
    wait_cnt(0);
    send(0, 8, 1'b0);
    chk_bit("rev_on_low", motor_1_on, 1'b0);
    chk_bit("rev_busy", m1_busy, 1'b1);
    n = 0;
    while (motor_1_dir == 1'b1 && n < 50) begin
      chk_bit("rev_busy_dead", m1_busy, 1'b1);
      cycle();
      n++;
    end
    chk_num("rev_dead_clocks", n, DEAD);
    exp_q.push_back(8'd4); exp_q.push_back(8'd8);
    for (int i = 0; i < 2; i++) measure(0, "rev_period_on");

    // ramp down to stop from HOLD 10
    wait_cnt(2);
    send(0, 10, 1'b0);
    wait_settle(0);
    wait_cnt(2);
    send(0, 0, 1'b0);
    chk_bit("down_ready_low", m1_cmd_ready, 1'b0);
    exp_q.push_back(8'd6); exp_q.push_back(8'd2); exp_q.push_back(8'd0);
    for (int i = 0; i < 3; i++) measure(0, "down_period_on");
    chk_bit("down_ready_idle", m1_cmd_ready, 1'b1);
    chk_bit("down_busy_idle", m1_busy, 1'b0);

    // estop with both motors running
    send(0, 12, 1'b1);
    repeat (20) cycle();
    estop = 1'b1;
    cycle();
    chk_bit("estop_m1_on", motor_1_on, 1'b0);
    chk_bit("estop_m2_on", motor_2_on, 1'b0);
    chk_bit("estop_m1_ready", m1_cmd_ready, 1'b0);
    chk_bit("estop_m2_ready", m2_cmd_ready, 1'b0);
    cycle(); cycle();
    estop = 1'b0;
    cycle();
    chk_bit("post_estop_m1_ready", m1_cmd_ready, 1'b1);
    chk_bit("post_estop_m2_ready", m2_cmd_ready, 1'b1);
    chk_bit("post_estop_m1_dir", motor_1_dir, 1'b1);
    chk_bit("post_estop_m2_dir", motor_2_dir, 1'b1);
    repeat (20) cycle();

    // asynchronous reset mid-ramp
    wait_cnt(2);
    send(0, 15, 1'b1);
    repeat (20) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk_bit("rst_m1_on", motor_1_on, 1'b0);
    chk_bit("rst_m1_dir", motor_1_dir, 1'b0);
    chk_bit("rst_m1_ready", m1_cmd_ready, 1'b1);
    chk_bit("rst_m1_busy", m1_busy, 1'b0);
    chk_bit("rst_m2_dir", motor_2_dir, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk_bit("rst_release_ready", m1_cmd_ready, 1'b1);

    // randomized commands and occasional estop pulses
    estop_left = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (!in_valid[c] && $urandom_range(0, 5) == 0) begin
          r = int'($urandom_range(0, 9));
          in_valid[c] = 1'b1;
          in_speed[c] = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(1, 14));
          in_dir[c]   = 1'($urandom_range(0, 1));
        end
      end
      if (estop_left > 0) begin
        estop = 1'b1;
        estop_left--;
      end else begin
        estop = 1'b0;
        if ($urandom_range(0, 299) == 0) estop_left = int'($urandom_range(1, 4));
      end
      cycle();
    end
    estop = 1'b0;
    for (int c = 0; c < 2; c++) in_valid[c] = 1'b0;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Sequences the two DC-motor channels that feed the L293D encoder. Accepts per-motor speed/direction commands over a valid/ready handshake. Generates PWM on the `motor_N_on` lines with a slew-limited duty ramp. Enforces a coast dead-time before any direction reversal so the bridge never switches polarity under drive. Sits between the control logic and the encoder, driving its `motor_1_on`, `motor_1_dir`, `motor_2_on` and `motor_2_dir` inputs.

## Interface
- `PWM_BITS`, 8: width of PWM counter and duty values.
- `RAMP_STEP`, 4: maximum duty change per PWM period. Must be at least 1.
- `DEAD_CYCLES`, 1000: coast clocks before a direction reversal. Must be at least 1.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `estop` in 1: synchronous emergency stop, level-sensitive.
- `m1_cmd_valid` in 1: motor 1 command valid.
- `m1_cmd_ready` out 1: motor 1 command accepted when valid and ready are both high.
- `m1_cmd_speed` in PWM_BITS: motor 1 target duty; 0 means stop.
- `m1_cmd_dir` in 1: motor 1 target direction; 1 is forward, 0 is back.
- `m2_cmd_valid`, `m2_cmd_ready`, `m2_cmd_speed`, `m2_cmd_dir`: same as motor 1, for motor 2.
- `motor_1_on` out 1: PWM drive for motor 1.
- `motor_1_dir` out 1: direction for motor 1.
- `motor_2_on` out 1: PWM drive for motor 2.
- `motor_2_dir` out 1: direction for motor 2.
- `m1_busy` out 1: high when motor 1 is in RAMP or DEAD.
- `m2_busy` out 1: high when motor 2 is in RAMP or DEAD.

## Operation
- **Shared PWM counter `cnt`:** free-running from 0 to 2^PWM_BITS−1, then wraps. A "wrap" is the cycle where `cnt == max`.
- **PWM output:** `on = (duty_cur > cnt) || (duty_cur == max)`. Max duty is therefore fully on; duty 0 is fully off.
- **Per-channel FSM states:** IDLE, RAMP, HOLD, DEAD.
- **IDLE:** `duty_cur = 0`, `ready = 1`. On accept:
  - speed 0: stay in IDLE.
  - otherwise: latch `dir_cur <= cmd_dir` and `target <= speed`, then go to RAMP.
- **HOLD:** `ready = 1`. On accept:
  - same direction: `target <= speed`, go to RAMP (or IDLE if speed 0 reaches duty 0).
  - opposite direction with nonzero speed: `duty_cur <= 0`, load dead counter with DEAD_CYCLES, latch target and new direction as pending, go to DEAD.
- **RAMP:** `ready = 0`.
  - At each wrap, `duty_cur` moves toward `target` by at most RAMP_STEP.
  - The step saturates at `target`, with no overshoot and no underflow or overflow.
  - When `duty_cur == target`: go to HOLD, or IDLE if target is 0.
- **DEAD:** `ready = 0`, `on = 0`, `dir_cur` unchanged.
  - Dead counter decrements each clock.
  - When it reaches 0: `dir_cur <= pending dir`, go to RAMP from duty 0.
- **Duty update rule:** `duty_cur` changes only at a wrap, except for the forced-zero on DEAD entry and on estop. This guarantees no partial PWM periods.
- **estop (highest priority):**
  - Next clock: both channels go to IDLE with `duty_cur = 0`, `on = 0`, and `dir_cur` held.
  - `ready = 0` while estop is high. Pending commands are discarded.
- **Channel independence:** the channels are independent, and simultaneous accepts on both are legal.
- **Speed 0 while in DEAD:** cannot happen, because `ready` is low in DEAD.

## Timing
- **Reset values:**
  - `cnt = 0`, all FSMs in IDLE, `duty_cur = 0`, `target = 0`, `dir_cur = 0`.
  - `motor_N_on = 0`, `motor_N_dir = 0`, `mN_cmd_ready = 1`, `mN_busy = 0`.
- **Register stage:** all outputs are registered.
- **Direction latency:** `motor_N_dir` reflects an IDLE accept 1 clock after the accept.
- **First duty change:** occurs at the first wrap after the accept. `on` reflects the new duty 1 clock after that wrap.
- **Reversal latency:** `on` goes low 1 clock after the accept. Direction flips DEAD_CYCLES clocks later, and the ramp begins at the next wrap.
- **Mid-operation reset:** `rst_n` low mid-operation clears everything immediately (asynchronous). Release is synchronised externally.

## Structure
- **Package `motor_seq_pkg`:**
  - `chan_state_t` enum: IDLE, RAMP, HOLD, DEAD.
  - Constants `DIR_FWD = 1'b1` and `DIR_BACK = 1'b0`.
- **Sub-module `motor_channel_fsm`**, instantiated twice. Inputs: `wrap`, `cnt`, `estop`, and the command handshake. Outputs: `on`, `dir`, `ready`, `busy`.
- **Top level:** owns the PWM counter and the wrap strobe only.

## Test plan
All scenarios use PWM_BITS=4, RAMP_STEP=4, DEAD_CYCLES=8.

- **Reset:** hold `rst_n` low mid-ramp → all outputs return to reset values with no clock edge needed; `ready = 1` after release.
- **Ramp up:** IDLE, accept m1 speed 10, dir 1 → `motor_1_dir = 1` next clock; duty steps 4, 8, 10 at successive wraps, then HOLD. At duty 10, `on` is high for exactly 10 of 16 clocks.
- **Full on:** accept m2 speed 15 → after 4 wraps, `motor_2_on` is high continuously.
- **Reversal:** HOLD at duty 8, dir 1; accept speed 8, dir 0 → `on = 0` next clock; `motor_1_dir` flips after 8 clocks; duty ramps 4, 8; `busy` is high throughout.
- **Ramp down to stop:** HOLD at duty 10; accept speed 0 → duty steps 6, 2, 0, then IDLE; `ready` is 0 until IDLE.
- **estop:** both motors running, `estop` high for 3 clocks → both `on = 0` next clock, both `ready = 0`; after release both channels are in IDLE at duty 0 with direction unchanged.
